// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
`timescale 1ns/1ps
package muldiv_pkg;

    localparam int MULDIV_DATA_W = 8;
    localparam int MULDIV_ADDR_W = 3;
    localparam int MULDIV_ITERS  = MULDIV_DATA_W;

    localparam logic [MULDIV_DATA_W-1:0] DIV0_QUOTIENT = 8'hFF;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WB_LO = 2'd2,
        WB_HI = 2'd3
    } stateT;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the shift-add multiplier or restoring divider.
// The accumulator is {upper, lower}: for MUL {partial product, remaining
// multiplier bits}; for DIV {remainder, dividend bits / quotient bits}.
// For DIV the quotient bit is returned separately and accOut[0] is left 0.
`timescale 1ns/1ps
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int DATA_W = MULDIV_DATA_W
) (
    input  logic [2*DATA_W-1:0] accIn,
    input  logic [DATA_W-1:0]   operand,
    input  logic                op,
    output logic [2*DATA_W-1:0] accOut,
    output logic                qBit
);

    logic [DATA_W:0]   mulSum;
    logic [DATA_W:0]   divTrial;
    logic [DATA_W-1:0] divDiff;

    // Single iteration for either operation
    always_comb begin
        // MUL: add multiplicand when the current multiplier LSB is set, then shift right
        mulSum   = {1'b0, accIn[2*DATA_W-1:DATA_W]} + (accIn[0] ? {1'b0, operand} : '0);
        // DIV: shift the next dividend bit into the remainder and trial-subtract
        divTrial = {accIn[2*DATA_W-1:DATA_W], accIn[DATA_W-1]};
        divDiff  = divTrial[DATA_W-1:0] - operand;
        qBit     = 1'b0;
        if (op == OP_DIV) begin
            qBit   = (divTrial >= {1'b0, operand});
            accOut = {(qBit ? divDiff : divTrial[DATA_W-1:0]), accIn[DATA_W-2:0], 1'b0};
        end else begin
            accOut = {mulSum, accIn[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/iterative_muldiv.sv
// Multi-cycle unsigned 8-bit multiply/divide unit with a two-cycle register
// bank write-back (low byte/quotient, then high byte/remainder).
// Optional feature macro: ITERATIVE_MULDIV_DIV_EN enables the divide path,
// the divide-by-zero shortcut and the divByZero flag; otherwise every
// request is a multiply and divByZero reads 0.
`timescale 1ns/1ps
module iterative_muldiv
    import muldiv_pkg::*;
#(
    parameter int DATA_W = MULDIV_DATA_W,
    parameter int ADDR_W = MULDIV_ADDR_W
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              start,
    input  logic              op,
    input  logic [DATA_W-1:0] operandA,
    input  logic [DATA_W-1:0] operandB,
    input  logic [ADDR_W-1:0] destReg,
    output logic              busy,
    output logic              done,
    output logic              divByZero,
    output logic              regWrite,
    output logic [ADDR_W-1:0] writeRegister,
    output logic [DATA_W-1:0] writeData
);

    localparam int CNT_W = $clog2(MULDIV_ITERS + 1);
`ifdef ITERATIVE_MULDIV_DIV_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif

    stateT               state, stateNext;
    logic [2*DATA_W-1:0] acc, accNext, stepAcc;
    logic                stepQBit;
    logic [DATA_W-1:0]   stepOperand;
    logic                opQ;
    logic [ADDR_W-1:0]   destQ;
    logic [CNT_W-1:0]    cnt, cntNext;
    logic                regWriteNext, doneNext;
    logic [ADDR_W-1:0]   writeRegisterNext;
    logic [DATA_W-1:0]   writeDataNext;
    logic                accept, reqDiv, reqDiv0;

    assign accept  = (state == IDLE) && start;
    assign reqDiv  = DIV_EN && (op == OP_DIV);
    assign reqDiv0 = reqDiv && (operandB == '0);
    assign busy    = (state != IDLE);

    muldiv_step #(.DATA_W(DATA_W)) uStep (
        .accIn  (acc),
        .operand(stepOperand),
        .op     (opQ),
        .accOut (stepAcc),
        .qBit   (stepQBit)
    );

    // Next state, datapath update and next value of the registered write port
    always_comb begin
        stateNext         = state;
        accNext           = acc;
        cntNext           = cnt;
        regWriteNext      = 1'b0;
        writeRegisterNext = '0;
        writeDataNext     = '0;
        doneNext          = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (reqDiv0) begin
                        // Skip iteration: quotient all-ones, remainder = dividend
                        stateNext         = WB_LO;
                        accNext           = {operandA, DATA_W'(DIV0_QUOTIENT)};
                        regWriteNext      = 1'b1;
                        writeRegisterNext = destReg;
                        writeDataNext     = DATA_W'(DIV0_QUOTIENT);
                    end else begin
                        stateNext = CALC;
                        accNext   = {{DATA_W{1'b0}}, (reqDiv ? operandA : operandB)};
                        cntNext   = CNT_W'(MULDIV_ITERS);
                    end
                end
            end
            CALC: begin
                accNext = {stepAcc[2*DATA_W-1:1], stepAcc[0] | stepQBit};
                cntNext = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    stateNext         = WB_LO;
                    regWriteNext      = 1'b1;
                    writeRegisterNext = destQ;
                    writeDataNext     = accNext[DATA_W-1:0];
                end
            end
            WB_LO: begin
                stateNext         = WB_HI;
                regWriteNext      = 1'b1;
                writeRegisterNext = destQ + ADDR_W'(1);
                writeDataNext     = acc[2*DATA_W-1:DATA_W];
                doneNext          = 1'b1;
            end
            WB_HI: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State, datapath and registered write-port outputs
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            opQ           <= OP_MUL;
            destQ         <= '0;
            stepOperand   <= '0;
            regWrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
            done          <= 1'b0;
        end else begin
            state         <= stateNext;
            acc           <= accNext;
            cnt           <= cntNext;
            regWrite      <= regWriteNext;
            writeRegister <= writeRegisterNext;
            writeData     <= writeDataNext;
            done          <= doneNext;
            if (accept) begin
                opQ         <= reqDiv ? OP_DIV : OP_MUL;
                destQ       <= destReg;
                stepOperand <= reqDiv ? operandB : operandA;
            end
        end
    end

`ifdef ITERATIVE_MULDIV_DIV_EN
    // Sticky divide-by-zero flag, re-evaluated on every accepted request
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            divByZero <= 1'b0;
        end else if (accept) begin
            divByZero <= reqDiv0;
        end
    end
`else
    assign divByZero = 1'b0;
`endif

endmodule

// File: doc/iterative_muldiv.md
# iterative_muldiv

Multi-cycle 8-bit multiply/divide unit sitting beside the ALU, between the register bank's read ports and its write port. It latches two operands read from the register bank plus a destination index, iterates one bit per cycle, and returns the 16-bit result through the register bank's single write port. The low byte goes to `destReg` and the high byte to `destReg+1` (mod 8), over two consecutive write cycles. While it runs, the controller stalls on `busy`.

## Interface
- `DATA_W`, 8, operand width; equals register width.
- `ADDR_W`, 3, register index width; 8 registers.
- `clk`  in  1  rising-edge clock shared with the register bank.
- `rstN`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  1  0 = MUL, 1 = DIV.
- `operandA`  in  DATA_W  multiplicand or dividend (from `readData1`).
- `operandB`  in  DATA_W  multiplier or divisor (from `readData2`).
- `destReg`  in  ADDR_W  destination index for the low byte or quotient.
- `busy`  out  1  high from the cycle after acceptance through the last write cycle.
- `done`  out  1  one-cycle pulse, coincident with the second write.
- `divByZero`  out  1  sticky until the next accepted `start`.
- `regWrite`  out  1  drives the register bank's write enable.
- `writeRegister`  out  ADDR_W  write index.
- `writeData`  out  DATA_W  write value.

## Operation
- States: IDLE, CALC, WB_LO, WB_HI.
- IDLE:
  - On `start`=1, latch `operandA`, `operandB`, `op` and `destReg`, clear `divByZero`, load iteration counter = DATA_W, and go to CALC.
  - Exception: DIV with `operandB`=0 sets `divByZero`, loads quotient=0xFF and remainder=`operandA`, and goes straight to WB_LO.
- CALC, one iteration per cycle:
  - MUL: shift-add into a 16-bit product register, LSB-first on the multiplier.
  - DIV: restoring division; 8-bit remainder and 8-bit quotient.
  - Counter decrements each cycle; on the cycle it reaches 0, go to WB_LO.
- WB_LO: `regWrite`=1, `writeRegister`=destReg, `writeData`=product[7:0] or quotient.
- WB_HI: `regWrite`=1, `writeRegister`=(destReg+1) mod 8, `writeData`=product[15:8] or remainder. `done`=1. Next state is IDLE.
- `start` while `busy` is ignored; nothing is queued.
- Arithmetic is unsigned. Product is the full 16 bits, so no overflow is possible.
- Index wrap: destReg=7 writes the high byte or remainder to register 0.
- Register 0 is an ordinary register: writes to it are performed.
- `regWrite`, `writeRegister` and `writeData` are registered outputs. All three are 0 outside WB_LO and WB_HI.

## Timing
- Cycle 0 is the edge at which `start` is sampled in IDLE.
- Normal latency:
  - CALC occupies cycles 1–8.
  - WB_LO is cycle 9 and WB_HI is cycle 10.
  - `busy`=1 during cycles 1–10 and IDLE returns at cycle 11.
  - A new `start` can be accepted at cycle 11.
- Divide-by-zero latency:
  - WB_LO is cycle 1 and WB_HI is cycle 2.
  - `busy`=1 during cycles 1–2.
- Reset values (all outputs 0, internal registers 0):
  - state=IDLE
  - `busy`=0, `done`=0, `divByZero`=0
  - `regWrite`=0, `writeRegister`=0, `writeData`=0
- Reset asserted mid-operation (any state) aborts immediately and asynchronously. No partial writes complete; a high byte is never written without its low byte.
- Operands are latched at acceptance. Register-bank writes from other sources during CALC do not affect the result.

## Configuration
- `ITERATIVE_MULDIV_DIV_EN`:
  - Defined: DIV path, the divide-by-zero shortcut and `divByZero` are present.
  - Undefined: `op` is ignored and every request is MUL. `divByZero` is tied to 0; the port is kept so the interface stays stable.

## Structure
- Shared package `muldiv_pkg` holds:
  - State enum: IDLE, CALC, WB_LO, WB_HI.
  - `OP_MUL`=1'b0 and `OP_DIV`=1'b1.
  - `MULDIV_ITERS`=DATA_W.
  - `DIV0_QUOTIENT`=8'hFF.
- One sub-module, `muldiv_step`: combinational single iteration. It takes the partial product or remainder, the operand and `op`, and returns the next partial product or remainder and the quotient bit.
- The FSM, counter and write-port mux live in the top.

## Test plan
- MUL 13×11, destReg=2 -> cycle 9 writes R2=0x8F; cycle 10 writes R3=0x00 with `done`=1.
- MUL 0xFF×0xFF, destReg=7 -> R7=0x01, then R0=0xFE (index wrap).
- DIV 200/7, destReg=4 -> R4=0x1C, then R5=0x04. `divByZero`=0 and latency is 10 cycles.
- DIV 0x55/0, destReg=1 -> cycle 1 writes R1=0xFF; cycle 2 writes R2=0x55 with `done`=1. `divByZero`=1 and stays 1 until the next start.
- `start` re-pulsed at cycles 3 and 10 of a MUL, then at cycle 11 -> the first two are ignored; the third is accepted and `busy` stays 1 through cycle 21.
- `rstN` low at cycle 5 of CALC -> all outputs 0 at once and no `regWrite` pulse. After release, a fresh MUL 3×4 yields 0x0C/0x00.
